// File: rtl/irq_ctrl_if.sv
// Register-port bus between a software master and the interrupt controller.
// An access is one strobe cycle followed by exactly one rdy_ cycle.
interface irq_ctrl_if;
    logic        cs_;
    logic        as_;
    logic        rw;
    logic [1:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rdy_;

    modport master (output cs_, as_, rw, addr, wr_data, input rd_data, rdy_);
    modport slave  (input cs_, as_, rw, addr, wr_data, output rd_data, rdy_);
endinterface

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller: synchronise, latch, present -> claim -> EOI.
// Edge source to cpu_irq takes SYNC_STAGES+2 cycles; register accesses never stall (rdy_ in the next cycle).
module irq_ctrl #(
    parameter int IRQ_CH      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IRQ_CH-1:0] src_irq,
    irq_ctrl_if.slave         bus,
    output logic [IRQ_CH-1:0] cpu_irq
);
    localparam int IDW = $clog2(IRQ_CH);

    typedef enum logic [1:0] {IDLE, PRESENT, SERVICE} state_t;
    state_t state_q, state_n;

    logic [IRQ_CH-1:0] sync_q [SYNC_STAGES];
    logic [IRQ_CH-1:0] s, s_d, rise;
    logic [IRQ_CH-1:0] type_q, enable_q, edge_pend_q, edge_pend_n;
    logic [IRQ_CH-1:0] pending, cand, win_oh, clr_mask;
    logic [IDW-1:0]    win_id, svc_id_q;
    logic              acc, rd_acc, wr_acc, claim, eoi_match;
    logic [31:0]       rd_mux;
    logic              unused_wr_bits;

    assign unused_wr_bits = ^bus.wr_data[31:IRQ_CH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            s_d <= '0;
        end else begin
            sync_q[0] <= src_irq;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            s_d <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;

    // Level channels bypass the latch so they track the source directly.
    assign pending = (type_q & edge_pend_q) | (~type_q & s);
    assign cand    = pending & enable_q;
    assign win_oh  = cand & (~cand + IRQ_CH'(1));

    always_comb begin
        win_id = '0;
        for (int i = IRQ_CH - 1; i >= 0; i--) begin
            if (cand[i]) win_id = IDW'(i);
        end
    end

    assign acc       = ~bus.cs_ & ~bus.as_;
    assign rd_acc    = acc & bus.rw;
    assign wr_acc    = acc & ~bus.rw;
    assign claim     = rd_acc && (bus.addr == 2'd3) && (state_q == PRESENT) && (cand != '0);
    assign eoi_match = wr_acc && (bus.addr == 2'd3) && (state_q == SERVICE) &&
                       (bus.wr_data[IDW-1:0] == svc_id_q);

    // Set beats clear so an edge arriving during a W1C is not lost.
    assign clr_mask    = ((wr_acc && bus.addr == 2'd1) ? bus.wr_data[IRQ_CH-1:0] : '0) |
                         (claim ? win_oh : '0);
    assign edge_pend_n = (edge_pend_q & ~clr_mask) | (rise & type_q);

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            2'd0: rd_mux = 32'(type_q);
            2'd1: rd_mux = 32'(pending);
            2'd2: rd_mux = 32'(enable_q);
            default: begin
                if (claim) begin
                    rd_mux     = 32'(win_id);
                    rd_mux[31] = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            type_q      <= '0;
            enable_q    <= '0;
            edge_pend_q <= '0;
            svc_id_q    <= '0;
            bus.rd_data <= '0;
            bus.rdy_    <= 1'b1;
        end else begin
            edge_pend_q <= edge_pend_n;
            if (wr_acc && bus.addr == 2'd0) type_q   <= bus.wr_data[IRQ_CH-1:0];
            if (wr_acc && bus.addr == 2'd2) enable_q <= bus.wr_data[IRQ_CH-1:0];
            if (claim) svc_id_q <= win_id;
            bus.rdy_    <= ~acc;
            bus.rd_data <= rd_acc ? rd_mux : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        cpu_irq = '0;
        case (state_q)
            IDLE: begin
                if (cand != '0) state_n = PRESENT;
            end
            PRESENT: begin
                cpu_irq = win_oh;
                if (claim)             state_n = SERVICE;
                else if (cand == '0)   state_n = IDLE;
            end
            SERVICE: begin
                if (eoi_match) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl; register reads are scored by a monitor against a queue of expected data.
module tb_irq_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] src_irq;
    logic [7:0] cpu_irq;

    irq_ctrl_if bus ();

    irq_ctrl #(.IRQ_CH(8), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .src_irq (src_irq),
        .bus     (bus),
        .cpu_irq (cpu_irq)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge where rdy_ should be low.
    task automatic bus_acc(input logic r, input logic [1:0] a, input logic [31:0] d,
                           input logic [31:0] exp);
        bus.cs_     = 1'b0;
        bus.as_     = 1'b0;
        bus.rw      = r;
        bus.addr    = a;
        bus.wr_data = d;
        exp_q.push_back(exp);
        @(negedge clk);
        bus.cs_ = 1'b1;
        bus.as_ = 1'b1;
    endtask

    task automatic bus_rd(input logic [1:0] a, input logic [31:0] exp);
        bus_acc(1'b1, a, 32'h0, exp);
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        bus_acc(1'b0, a, d, 32'h0);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.rdy_ === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rdy_ spurious: rd_data 0x%08h with no access outstanding", bus.rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("rd_data", bus.rd_data, mon_exp);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        src_irq     = 8'h00;
        bus.cs_     = 1'b1;
        bus.as_     = 1'b1;
        bus.rw      = 1'b1;
        bus.addr    = 2'd0;
        bus.wr_data = 32'h0;
        cyc(1);
        chk("reset cpu_irq", 32'(cpu_irq), 32'h0);
        chk("reset rdy_", 32'(bus.rdy_), 32'h1);
        chk("reset rd_data", bus.rd_data, 32'h0);
        cyc(1);
        reset = 1'b0;
        cyc(2);
        chk("idle cpu_irq", 32'(cpu_irq), 32'h0);

        // Idle read of ENABLE: one rdy_ cycle, then released.
        bus_rd(2'd2, 32'h0);
        chk("rdy_ low after strobe", 32'(bus.rdy_), 32'h0);
        cyc(1);
        chk("rdy_ released", 32'(bus.rdy_), 32'h1);

        // Edge channel 3: latency, claim, pending cleared, EOI.
        bus_wr(2'd0, 32'h08);
        bus_wr(2'd2, 32'h08);
        src_irq = 8'h08;
        cyc(1);
        src_irq = 8'h00;
        cyc(2);
        chk("edge3 not yet", 32'(cpu_irq), 32'h0);
        cyc(1);
        chk("edge3 presented", 32'(cpu_irq), 32'h08);
        bus_rd(2'd3, 32'h8000_0003);
        chk("edge3 service cpu_irq", 32'(cpu_irq), 32'h0);
        bus_rd(2'd1, 32'h0);
        bus_wr(2'd3, 32'h3);
        bus_rd(2'd3, 32'h0);
        chk("edge3 idle cpu_irq", 32'(cpu_irq), 32'h0);

        // Level preemption: 5 then 1.
        bus_wr(2'd0, 32'h00);
        bus_wr(2'd2, 32'hFF);
        src_irq = 8'h20;
        cyc(4);
        chk("level5 presented", 32'(cpu_irq), 32'h20);
        src_irq = 8'h22;
        cyc(3);
        chk("level1 preempts", 32'(cpu_irq), 32'h02);
        bus_rd(2'd3, 32'h8000_0001);
        chk("svc1 cpu_irq", 32'(cpu_irq), 32'h0);

        // Mismatched EOI and disabling do not leave SERVICE.
        bus_wr(2'd3, 32'h4);
        cyc(2);
        chk("bad eoi stays", 32'(cpu_irq), 32'h0);
        bus_rd(2'd3, 32'h0);
        src_irq = 8'h20;
        bus_wr(2'd2, 32'h00);
        cyc(3);
        bus_wr(2'd2, 32'hFF);
        cyc(2);
        chk("disable keeps service", 32'(cpu_irq), 32'h0);
        bus_wr(2'd3, 32'h1);
        cyc(1);
        chk("eoi re-presents 5", 32'(cpu_irq), 32'h20);

        // W1C colliding with a rising edge on channel 2.
        bus_wr(2'd0, 32'h04);
        src_irq = 8'h24;
        cyc(2);
        bus_wr(2'd1, 32'h04);
        bus_rd(2'd1, 32'h24);
        chk("edge2 presented", 32'(cpu_irq), 32'h04);
        bus_wr(2'd1, 32'h20);
        bus_rd(2'd1, 32'h24);
        bus_wr(2'd1, 32'h04);
        bus_rd(2'd1, 32'h20);
        chk("edge2 cleared", 32'(cpu_irq), 32'h20);

        // Reset while in SERVICE with a read response outstanding.
        bus_rd(2'd3, 32'h8000_0005);
        chk("svc5 cpu_irq", 32'(cpu_irq), 32'h0);
        bus.cs_  = 1'b0;
        bus.as_  = 1'b0;
        bus.rw   = 1'b1;
        bus.addr = 2'd2;
        #7;
        chk("inflight rdy_", 32'(bus.rdy_), 32'h0);
        chk("inflight rd_data", bus.rd_data, 32'hFF);
        reset = 1'b1;
        #1;
        chk("async rst rdy_", 32'(bus.rdy_), 32'h1);
        chk("async rst rd_data", bus.rd_data, 32'h0);
        chk("async rst cpu_irq", 32'(cpu_irq), 32'h0);
        @(negedge clk);
        bus.cs_ = 1'b1;
        bus.as_ = 1'b1;
        cyc(1);
        reset = 1'b0;
        bus_rd(2'd0, 32'h0);
        bus_wr(2'd2, 32'h20);
        cyc(2);
        chk("post-reset idle presents", 32'(cpu_irq), 32'h20);

        cyc(2);
        chk("no outstanding access", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Programmable interrupt controller that sits between the external interrupt sources and the CPU control unit's 8-bit irq input.
- Synchronises the raw source lines.
- Latches edge events and tracks level sources.
- Selects one winner by fixed priority and presents it to the CPU.
- Sequences a present -> claim -> end-of-interrupt handshake with software through a small memory-mapped register port.

Parameters:
IRQ_CH, 8, number of interrupt source channels (fixed to the CPU irq width)
SYNC_STAGES, 2, flip-flop stages in each source synchroniser (≥2)

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high
src_irq  input  IRQ_CH  raw interrupt sources, asynchronous to clk
cs_  input  1  register port chip select, active-low
as_  input  1  register port address strobe, active-low
rw  input  1  1 = read, 0 = write
addr  input  2  register index
wr_data  input  32  write data
rd_data  output  32  read data, valid while rdy_ is low
rdy_  output  1  access complete, active-low
cpu_irq  output  IRQ_CH  one-hot presented interrupt, to CPU irq input

Behaviour:
- Reset values: rd_data = 0, rdy_ = 1, cpu_irq = 0, type = 0 (all level), enable = 0, pending = 0, state = IDLE, synchronisers = 0.
- Synchronisers: each src_irq bit passes through SYNC_STAGES flops, giving s[i]. Edge detect compares s[i] with one more delayed copy; a rising edge fires rise[i].
- Pending for an edge channel (type[i] = 1):
  - Set on rise[i].
  - Cleared by a W1C write or by a claim of that channel.
  - A set and a clear in the same cycle: set wins.
- Pending for a level channel (type[i] = 0): pending[i] = s[i] combinationally from the synchroniser output. Claim and W1C have no effect.
- Candidates: cand = pending & enable. The winner is the lowest-numbered set bit (channel 0 has the highest priority).
- Registers (addr):
  - 0 TYPE: R/W, bits[7:0].
  - 1 PENDING: read bits[7:0]; a write clears edge pending bits where wr_data = 1.
  - 2 ENABLE: R/W, bits[7:0].
  - 3 CLAIM/EOI: a read in PRESENT returns {1'b1, 28'b0, win_id[2:0]} and claims; a read in any other state returns 0. A write is an EOI.
  - Unused bits read 0.
- Bus timing:
  - An access starts in a cycle where cs_ = 0 and as_ = 0.
  - Registers update at the end of that cycle.
  - rdy_ = 0 and rd_data are valid in the next cycle only, then rdy_ returns to 1. Back-to-back accesses are allowed.
  - rd_data = 0 on writes.
- State machine:
  - IDLE: cpu_irq = 0. Go to PRESENT when cand != 0.
  - PRESENT: cpu_irq = one-hot of the winner, re-evaluated every cycle, so a higher-priority arrival replaces the presented channel. If cand becomes 0, return to IDLE. A CLAIM read records the current winner in svc_id, clears its pending bit if it is an edge channel, and moves to SERVICE.
  - SERVICE: cpu_irq = 0 (no nesting). An EOI write with wr_data[2:0] == svc_id returns to IDLE. A mismatched EOI is ignored. Reads of addr 3 return 0.
- Configuration side effects: disabling the in-service channel via ENABLE does not leave SERVICE; only a matching EOI does.
- Reset mid-operation: all state returns immediately to reset values, and an in-flight access gets no rdy_.
- Latency: src_irq rising edge to cpu_irq asserted = SYNC_STAGES + 2 cycles (synchroniser, edge/pending register, state register).

Test Plan:
- Reset then idle: src_irq = 0 → cpu_irq = 0, rdy_ = 1, and a read of addr 2 returns 0 with rdy_ low exactly 1 cycle after the strobe.
- Edge channel 3:
  - Setup: TYPE = 0x08, ENABLE = 0x08, then a 1-cycle pulse on src_irq[3].
  - Expected: cpu_irq = 0x08 after SYNC_STAGES + 2 cycles; a CLAIM read returns 0x80000003, after which cpu_irq = 0 and PENDING reads 0x00.
  - Then an EOI write with data 3 → IDLE.
- Priority preemption: ENABLE = 0xFF (all level), assert src_irq[5]; cpu_irq = 0x20. Then assert src_irq[1] → cpu_irq = 0x02 before any claim, and the claim returns id 1.
- EOI mismatch: in SERVICE with svc_id = 1, write EOI with data 4 → state stays SERVICE and cpu_irq stays 0. Then write EOI with data 1 → re-presents any pending channel (0x20 if src_irq[5] is still high).
- Edge W1C collision: a W1C of bit 2 in the same cycle as rise[2] → PENDING[2] stays 1. A W1C of a level bit → no change.
- Async reset asserted while in SERVICE with an access outstanding → all outputs return to reset values that cycle, and the state is IDLE after release.
